serial_subtractor: RTL and testbench

Bit-serial subtractor computing lhs - rhs - bin, one bit per clock, LSB first. It is the arithmetic inverse of the combinational ripple adder used in the examples. Operands enter on a valid/ready handshake and the result leaves on a second handshake, so the block can sit between a stimulus source and a checker or sink. Area is traded for latency: one full-subtractor cell is reused WIDTH times.

---
 rtl/serial_subtractor_if.sv | 34 +++
 rtl/serial_subtractor.sv | 130 +++++++++++++
 tb/tb_serial_subtractor.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor_if
// Purpose  : Operand and result handshake bundle for serial_subtractor.
//            The operand side carries in_valid/in_ready with lhs, rhs, bin.
//            The result side carries out_valid/out_ready with diff, bout.
// Modports : master - the stimulus/sink side (drives operands, out_ready)
//            slave  - the subtractor (drives in_ready, out_valid, diff, bout)
// Revision : 1.0 - initial release
// ============================================================================
interface serial_subtractor_if #(
   parameter int WIDTH = 2
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] lhs;
   logic [WIDTH-1:0] rhs;
   logic             bin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] diff;
   logic             bout;

   modport master (
      output in_valid, lhs, rhs, bin, out_ready,
      input  in_ready, out_valid, diff, bout
   );

   modport slave (
      input  in_valid, lhs, rhs, bin, out_ready,
      output in_ready, out_valid, diff, bout
   );
endinterface
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor
// Purpose  : Bit-serial subtractor producing lhs - rhs - bin, LSB first, one
//            bit per clock through a single reused full-subtractor cell.
//            The result appears WIDTH clocks after the operand accept and is
//            held until the result handshake completes.
// Ports    : clk    - clock, rising edge
//            reset  - asynchronous, active-low
//            bus    - serial_subtractor_if.slave (operand/result handshakes)
// Revision : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
   parameter int WIDTH = 2
) (
   input  wire                  clk,
   input  wire                  reset,
   serial_subtractor_if.slave   bus
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] lhs_q, lhs_d;
   logic [WIDTH-1:0] rhs_q, rhs_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             borrow_q, borrow_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             bout_q, bout_d;

   // Full-subtractor cell on the current LSBs
   logic             d_bit;
   logic             borrow_nxt;
   logic [WIDTH-1:0] res_nxt;

   assign d_bit      = lhs_q[0] ^ rhs_q[0] ^ borrow_q;
   assign borrow_nxt = (~lhs_q[0] & rhs_q[0]) | (~(lhs_q[0] ^ rhs_q[0]) & borrow_q);

   // New difference bit enters at the MSB so that after WIDTH shifts the
   // first (LSB) bit has arrived at position 0.
   generate
      if (WIDTH > 1) begin : g_res_wide
         assign res_nxt = {d_bit, res_q[WIDTH-1:1]};
      end else begin : g_res_one
         assign res_nxt = d_bit;
      end
   endgenerate

   always_comb begin
      state_d  = state_q;
      lhs_d    = lhs_q;
      rhs_d    = rhs_q;
      res_d    = res_q;
      borrow_d = borrow_q;
      cnt_d    = cnt_q;
      diff_d   = diff_q;
      bout_d   = bout_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               lhs_d    = bus.lhs;
               rhs_d    = bus.rhs;
               borrow_d = bus.bin;
               cnt_d    = '0;
               state_d  = BUSY;
            end
         end
         BUSY: begin
            lhs_d    = lhs_q >> 1;
            rhs_d    = rhs_q >> 1;
            res_d    = res_nxt;
            borrow_d = borrow_nxt;
            cnt_d    = cnt_q + CW'(1);
            // Output registers only change on the final bit, so a result
            // from a previous operation stays visible until then.
            if (cnt_q == LAST_CNT) begin
               diff_d  = res_nxt;
               bout_d  = borrow_nxt;
               state_d = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         lhs_q    <= '0;
         rhs_q    <= '0;
         res_q    <= '0;
         borrow_q <= 1'b0;
         cnt_q    <= '0;
         diff_q   <= '0;
         bout_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         lhs_q    <= lhs_d;
         rhs_q    <= rhs_d;
         res_q    <= res_d;
         borrow_q <= borrow_d;
         cnt_q    <= cnt_d;
         diff_q   <= diff_d;
         bout_q   <= bout_d;
      end
   end

   // Handshake flags decode the state register only
   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.diff      = diff_q;
   assign bus.bout      = bout_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_subtractor
// Purpose  : Directed, self-checking bench for serial_subtractor at WIDTH 1,
//            2 and 8, with hand-computed expected results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

   logic clk = 1'b0;
   logic rst1, rst2, rst8;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   serial_subtractor_if #(.WIDTH(1)) if1 ();
   serial_subtractor_if #(.WIDTH(2)) if2 ();
   serial_subtractor_if #(.WIDTH(8)) if8 ();

   serial_subtractor #(.WIDTH(1)) u_dut1 (.clk(clk), .reset(rst1), .bus(if1));
   serial_subtractor #(.WIDTH(2)) u_dut2 (.clk(clk), .reset(rst2), .bus(if2));
   serial_subtractor #(.WIDTH(8)) u_dut8 (.clk(clk), .reset(rst8), .bus(if8));

   typedef struct {
      logic [31:0] l;
      logic [31:0] r;
      logic        b;
      logic [31:0] ed;
      logic        eb;
   } vec_t;

   vec_t v1 [8];
   vec_t v2 [3];
   vec_t v8 [2];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   task automatic drive(input int w, input logic v, input logic [31:0] l,
                        input logic [31:0] r, input logic b, input logic ordy);
      case (w)
         1: begin
            if1.in_valid = v; if1.lhs = l[0:0]; if1.rhs = r[0:0];
            if1.bin = b; if1.out_ready = ordy;
         end
         2: begin
            if2.in_valid = v; if2.lhs = l[1:0]; if2.rhs = r[1:0];
            if2.bin = b; if2.out_ready = ordy;
         end
         default: begin
            if8.in_valid = v; if8.lhs = l[7:0]; if8.rhs = r[7:0];
            if8.bin = b; if8.out_ready = ordy;
         end
      endcase
   endtask

   task automatic sample(input int w, output logic ir, output logic ov,
                         output logic [31:0] d, output logic bo);
      case (w)
         1:       begin ir = if1.in_ready; ov = if1.out_valid; d = 32'(if1.diff); bo = if1.bout; end
         2:       begin ir = if2.in_ready; ov = if2.out_valid; d = 32'(if2.diff); bo = if2.bout; end
         default: begin ir = if8.in_ready; ov = if8.out_valid; d = 32'(if8.diff); bo = if8.bout; end
      endcase
   endtask

   // Count edges until out_valid, bounded so a stuck DUT cannot hang the run
   task automatic wait_ov(input int w, output int n);
      logic ir, ov, bo;
      logic [31:0] d;
      n = 0;
      sample(w, ir, ov, d, bo);
      while (!ov && n < 40) begin
         @(posedge clk); #1;
         n++;
         sample(w, ir, ov, d, bo);
      end
   endtask

   // One full operation; called #1 after a rising edge with the DUT idle
   task automatic run_op(input int w, input vec_t v, input string nm);
      logic ir, ov, bo;
      logic [31:0] d;
      int n;
      sample(w, ir, ov, d, bo);
      chk({nm, " in_ready_before"}, 32'(ir), 32'd1);
      drive(w, 1'b1, v.l, v.r, v.b, 1'b1);
      @(posedge clk); #1;
      // Scramble operands after accept; they must not affect the result
      drive(w, 1'b0, ~v.l, ~v.r, ~v.b, 1'b1);
      wait_ov(w, n);
      chk({nm, " latency"}, 32'(n), 32'(w));
      sample(w, ir, ov, d, bo);
      chk({nm, " diff"}, d, v.ed);
      chk({nm, " bout"}, 32'(bo), 32'(v.eb));
      @(posedge clk); #1;
      sample(w, ir, ov, d, bo);
      chk({nm, " out_valid_after"}, 32'(ov), 32'd0);
      chk({nm, " in_ready_after"}, 32'(ir), 32'd1);
   endtask

   initial begin
      logic ir, ov, bo;
      logic [31:0] d;
      int n;
      int acc [3];

      // W1 exhaustive table: diff = l^r^b, bout = (l < r+b)
      v1[0] = '{0, 0, 0, 0, 0};  v1[1] = '{0, 0, 1, 1, 1};
      v1[2] = '{0, 1, 0, 1, 1};  v1[3] = '{0, 1, 1, 0, 1};
      v1[4] = '{1, 0, 0, 1, 0};  v1[5] = '{1, 0, 1, 0, 0};
      v1[6] = '{1, 1, 0, 0, 0};  v1[7] = '{1, 1, 1, 1, 1};
      // W2 back-to-back: 3-1-0=2, 0-0-1=-1->3, 2-2-0=0
      v2[0] = '{3, 1, 0, 2, 0};  v2[1] = '{0, 0, 1, 3, 1};
      v2[2] = '{2, 2, 0, 0, 0};
      // W8: 200-55-1=144, 5-10-0=-5->251
      v8[0] = '{200, 55, 1, 144, 0};  v8[1] = '{5, 10, 0, 251, 1};

      drive(1, 1'b0, 0, 0, 1'b0, 1'b1);
      drive(2, 1'b0, 0, 0, 1'b0, 1'b1);
      drive(8, 1'b0, 0, 0, 1'b0, 1'b1);
      rst1 = 1'b0; rst2 = 1'b0; rst8 = 1'b0;
      #1;
      for (int w = 1; w <= 8; w = w * 2) begin
         sample(w, ir, ov, d, bo);
         if (w == 4) continue;
         chk($sformatf("reset W%0d in_ready", w), 32'(ir), 32'd1);
         chk($sformatf("reset W%0d out_valid", w), 32'(ov), 32'd0);
         chk($sformatf("reset W%0d diff", w), d, 32'd0);
         chk($sformatf("reset W%0d bout", w), 32'(bo), 32'd0);
      end
      repeat (2) @(posedge clk);
      #1;
      rst1 = 1'b1; rst2 = 1'b1; rst8 = 1'b1;
      @(posedge clk); #1;

      // W2 single operation: 1-3-1 = -3 -> 1, borrow
      run_op(2, '{1, 3, 1, 1, 1}, "w2_single");

      // W1 exhaustive sweep
      for (int i = 0; i < 8; i++)
         run_op(1, v1[i], $sformatf("w1_vec%0d", i));

      // W8 two operations
      for (int i = 0; i < 2; i++)
         run_op(8, v8[i], $sformatf("w8_vec%0d", i));

      // W2 back-to-back with in_valid held high
      for (int k = 0; k < 3; k++) begin
         sample(2, ir, ov, d, bo);
         chk($sformatf("b2b%0d in_ready", k), 32'(ir), 32'd1);
         drive(2, 1'b1, v2[k].l, v2[k].r, v2[k].b, 1'b1);
         acc[k] = cyc;
         @(posedge clk); #1;
         drive(2, 1'b1, 32'd1, 32'd3, 1'b1, 1'b1);
         wait_ov(2, n);
         chk($sformatf("b2b%0d latency", k), 32'(n), 32'd2);
         sample(2, ir, ov, d, bo);
         chk($sformatf("b2b%0d diff", k), d, v2[k].ed);
         chk($sformatf("b2b%0d bout", k), 32'(bo), 32'(v2[k].eb));
         if (k > 0)
            chk($sformatf("b2b%0d spacing", k), 32'(acc[k] - acc[k-1]), 32'd4);
         @(posedge clk); #1;
      end
      drive(2, 1'b0, 0, 0, 1'b0, 1'b1);
      // The held in_valid may have started a 4th op on the last edge; clear it
      rst2 = 1'b0; #1; rst2 = 1'b1;
      @(posedge clk); #1;

      // W2 backpressure: (3,1,0) held for 5 cycles with out_ready low
      drive(2, 1'b1, 3, 1, 1'b0, 1'b0);
      @(posedge clk); #1;
      drive(2, 1'b0, 0, 3, 1'b1, 1'b0);
      wait_ov(2, n);
      chk("bp latency", 32'(n), 32'd2);
      for (int c = 0; c < 5; c++) begin
         drive(2, 1'b1, 32'(c), 32'(c + 1), c[0], 1'b0);
         @(posedge clk); #1;
         sample(2, ir, ov, d, bo);
         chk($sformatf("bp hold%0d out_valid", c), 32'(ov), 32'd1);
         chk($sformatf("bp hold%0d diff", c), d, 32'd2);
         chk($sformatf("bp hold%0d bout", c), 32'(bo), 32'd0);
      end
      drive(2, 1'b0, 0, 0, 1'b0, 1'b1);
      @(posedge clk); #1;
      sample(2, ir, ov, d, bo);
      chk("bp release in_ready", 32'(ir), 32'd1);
      chk("bp release out_valid", 32'(ov), 32'd0);
      chk("bp release diff_kept", d, 32'd2);

      // W8 reset one cycle into an operation
      drive(8, 1'b1, 200, 55, 1'b1, 1'b1);
      @(posedge clk); #1;
      drive(8, 1'b0, 0, 0, 1'b0, 1'b1);
      @(posedge clk); #1;
      rst8 = 1'b0;
      #1;
      sample(8, ir, ov, d, bo);
      chk("rst_mid in_ready", 32'(ir), 32'd1);
      chk("rst_mid out_valid", 32'(ov), 32'd0);
      chk("rst_mid diff", d, 32'd0);
      chk("rst_mid bout", 32'(bo), 32'd0);
      repeat (12) begin
         @(posedge clk); #1;
         sample(8, ir, ov, d, bo);
         if (ov) chk("rst_mid spurious out_valid", 32'(ov), 32'd0);
      end
      rst8 = 1'b1;
      @(posedge clk); #1;
      run_op(8, v8[0], "rst_mid fresh");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
